// File: rtl/cla_pipe_addsub_pkg.sv
// Shared ALU definitions for the pipelined add/subtract unit.
// Op encodings, flag-bundle bit positions and the carry-in selection rule.
package cla_pipe_addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } alu_op_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 3;
  localparam int FLAG_W  = 4;

  // SUB/SBB run as A + ~B + cin; SBB's borrow-in is !cin, so cin passes straight through.
  function automatic logic op_carry_in(input alu_op_e op, input logic cin);
    logic c;
    c = 1'b0;
    unique case (op)
      OP_ADD: c = 1'b0;
      OP_SUB: c = 1'b1;
      OP_ADC: c = cin;
      OP_SBB: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_chunk.sv
// Combinational CW-bit carry-lookahead adder: 4-bit groups with group P/G and a second lookahead level.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module cla_pipe_addsub_chunk #(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          c_msb
);

  localparam int NG = CW / 4;

  logic [CW-1:0] w_p;
  logic [CW-1:0] w_g;
  logic [CW-1:0] w_c;
  logic [NG-1:0] w_gp;
  logic [NG-1:0] w_gg;
  logic [NG:0]   w_gc;

  assign w_p = a ^ b;
  assign w_g = a & b;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    localparam int B = 4 * j;
    assign w_gp[j] = &w_p[B+3:B];
    assign w_gg[j] = w_g[B+3]
                   | (w_p[B+3] & w_g[B+2])
                   | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_c[B]   = w_gc[j];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[j]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[j]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[j]);
  end

  // Second level: group carries from group generate/propagate only.
  always_comb begin
    logic c;
    c = cin;
    w_gc = '0;
    for (int j = 0; j < NG; j++) begin
      w_gc[j] = c;
      c = w_gg[j] | (w_gp[j] & c);
    end
    w_gc[NG] = c;
  end

  assign sum   = w_p ^ w_c;
  assign cout  = w_gc[NG];
  assign c_msb = w_c[CW-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/sub/adc/sbb with flags: one CW-bit lookahead chunk per stage, carry registered between stages.
// NSTAGE cycles latency, one op per clock; every stage holds while the output is stalled.
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NSTAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cf,
  output logic             out_of,
  output logic             out_zf,
  output logic             out_sf
);

  localparam int CW = WIDTH / NSTAGE;

  logic              w_stall;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin0;
  logic [FLAG_W-1:0] w_flags;

  assign w_b_eff   = in_op[0] ? ~in_b : in_b;
  assign w_cin0    = op_carry_in(alu_op_e'(in_op), in_cin);
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;

  // r_ab holds finished sum chunks below chunk k and still-unsummed A chunks above it;
  // r_b holds only the unsummed B chunks, shifted down so its bottom chunk is next.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    localparam int BW = WIDTH - k * CW;

    logic             w_vld_in;
    logic [WIDTH-1:0] w_ab_in;
    logic [BW-1:0]    w_b_in;
    logic             w_c_in;
    logic             w_z_in;
    logic [CW-1:0]    w_csum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_ab_nx;

    logic             r_vld;
    logic [WIDTH-1:0] r_ab;
    logic             r_c;
    logic             r_z;
    logic             r_cmsb;

    if (k == 0) begin : g_src
      assign w_vld_in = in_valid;
      assign w_ab_in  = in_a;
      assign w_b_in   = w_b_eff;
      assign w_c_in   = w_cin0;
      assign w_z_in   = 1'b1;
    end else begin : g_src
      assign w_vld_in = g_stg[k-1].r_vld;
      assign w_ab_in  = g_stg[k-1].r_ab;
      assign w_b_in   = g_stg[k-1].g_fwd.r_b;
      assign w_c_in   = g_stg[k-1].r_c;
      assign w_z_in   = g_stg[k-1].r_z;
    end

    cla_pipe_addsub_chunk #(.CW(CW)) u_chunk (
      .a     (w_ab_in[k*CW +: CW]),
      .b     (w_b_in[CW-1:0]),
      .cin   (w_c_in),
      .sum   (w_csum),
      .cout  (w_cout),
      .c_msb (w_cmsb)
    );

    always_comb begin
      w_ab_nx = w_ab_in;
      w_ab_nx[k*CW +: CW] = w_csum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_ab   <= '0;
        r_c    <= 1'b0;
        r_z    <= 1'b0;
        r_cmsb <= 1'b0;
      end else if (!w_stall) begin
        r_vld  <= w_vld_in;
        r_ab   <= w_ab_nx;
        r_c    <= w_cout;
        r_z    <= w_z_in & ~|w_csum;
        r_cmsb <= w_cmsb;
      end
    end

    if (k < NSTAGE - 1) begin : g_fwd
      logic [BW-CW-1:0] r_b;
      logic             w_unused_cmsb;

      assign w_unused_cmsb = r_cmsb;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_b <= '0;
        end else if (!w_stall) begin
          r_b <= w_b_in[BW-1:CW];
        end
      end
    end
  end

  assign w_flags[FLAG_CF] = g_stg[NSTAGE-1].r_c;
  assign w_flags[FLAG_OF] = g_stg[NSTAGE-1].r_c ^ g_stg[NSTAGE-1].r_cmsb;
  assign w_flags[FLAG_ZF] = g_stg[NSTAGE-1].r_z;
  assign w_flags[FLAG_SF] = g_stg[NSTAGE-1].r_ab[WIDTH-1];

  assign out_valid = g_stg[NSTAGE-1].r_vld;
  assign out_sum   = g_stg[NSTAGE-1].r_ab;
  assign out_cf    = w_flags[FLAG_CF];
  assign out_of    = w_flags[FLAG_OF];
  assign out_zf    = w_flags[FLAG_ZF];
  assign out_sf    = w_flags[FLAG_SF];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and random checks of cla_pipe_addsub against an arithmetic reference model.
module tb_cla_pipe_addsub;

  localparam int W  = 32;
  localparam int NS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cf;
  logic         out_of;
  logic         out_zf;
  logic         out_sf;

  int errors = 0;
  int checks = 0;

  // Expected results packed as {cf, of, zf, sf, sum}.
  logic [W+3:0] q[$];
  logic [W+3:0] held;
  bit           was_stall = 1'b0;
  int           emits = 0;
  int           stalls = 0;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(W), .NSTAGE(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cf    (out_cf),
    .out_of    (out_of),
    .out_zf    (out_zf),
    .out_sf    (out_sf)
  );

  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op, input logic cin);
    longint ua, ub, sa, sb, r, rs, lim;
    logic [W-1:0] s;
    logic cf, of;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   begin r = ua + ub;                     rs = sa + sb;                     end
      2'b01:   begin r = ua - ub;                     rs = sa - sb;                     end
      2'b10:   begin r = ua + ub + longint'(cin);     rs = sa + sb + longint'(cin);     end
      default: begin r = ua - ub - longint'(!cin);    rs = sa - sb - longint'(!cin);    end
    endcase
    s   = r[W-1:0];
    lim = longint'(1) << (W - 1);
    cf  = op[0] ? (r >= 0) : (r >= (longint'(1) << W));
    of  = (rs < -lim) || (rs > lim - 1);
    return {cf, of, (s == '0), s[W-1], s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W+3:0] exp);
    chk({tag, "_sum"}, 64'(out_sum), 64'(exp[W-1:0]));
    chk({tag, "_cf"},  64'(out_cf),  64'(exp[W+3]));
    chk({tag, "_of"},  64'(out_of),  64'(exp[W+2]));
    chk({tag, "_zf"},  64'(out_zf),  64'(exp[W+1]));
    chk({tag, "_sf"},  64'(out_sf),  64'(exp[W]));
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic c);
    in_a   = a;
    in_b   = b;
    in_op  = op;
    in_cin = c;
  endtask

  task automatic drive_rand();
    drive(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // One clock of streaming: score emission, record acceptance, check stall stability.
  task automatic cycle();
    logic acc, emit;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (out_valid && !out_ready) begin
      stalls++;
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      if (was_stall)
        chk("stall_hold", 64'({out_cf, out_of, out_zf, out_sf, out_sum}), 64'(held));
      held = {out_cf, out_of, out_zf, out_sf, out_sum};
      was_stall = 1'b1;
    end else begin
      was_stall = 1'b0;
    end
    if (emit) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        chk_out("stream", q.pop_front());
        emits++;
      end
    end
    if (acc) q.push_back(model(in_a, in_b, in_op, in_cin));
    @(posedge clk);
    #1;
  endtask

  // Issue one op on an idle pipe and check exact latency and result.
  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic c, input logic [W+3:0] exp);
    drive(a, b, op, c);
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i < NS; i++) begin
      chk({tag, "_early"}, 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk_out(tag, exp);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] ta[10];
  logic [W-1:0] tb[10];
  logic [1:0]   top[10];
  logic         tc[10];

  initial begin
    int  idx;
    logic acc;

    // Reset held with in_valid asserted.
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_rand();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_sum",   64'(out_sum),   64'(0));
      chk("rst_flags", 64'({out_cf, out_of, out_zf, out_sf}), 64'(0));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Carry across the chunk boundary, signed overflow both ways.
    single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, {4'b1010, 32'h0000_0000});
    single("sub_of",   32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, {4'b1100, 32'h7FFF_FFFF});
    single("adc_of",   32'h7FFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, {4'b0101, 32'h8000_0000});
    chk("idle_after_single", 64'(out_valid), 64'(0));

    // Back-to-back random stream.
    q.delete();
    emits = 0;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    for (int t = 0; t < NS + 4 && q.size() > 0; t++) begin
      chk("stream_contig", 64'(out_valid), 64'(1));
      cycle();
    end
    chk("stream_count", 64'(emits), 64'(16));
    chk("stream_left",  64'(q.size()), 64'(0));

    // Backpressure for 5 cycles mid-stream.
    for (int i = 0; i < 10; i++) begin
      ta[i]  = W'($urandom);
      tb[i]  = W'($urandom);
      top[i] = 2'($urandom_range(0, 3));
      tc[i]  = 1'($urandom_range(0, 1));
    end
    emits  = 0;
    stalls = 0;
    idx    = 0;
    for (int cyc = 0; cyc < 60 && (idx < 10 || q.size() > 0); cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      if (idx < 10) begin
        drive(ta[idx], tb[idx], top[idx], tc[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      cycle();
      if (acc) idx++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk("bp_count",  64'(emits),    64'(10));
    chk("bp_stalls", 64'(stalls),   64'(5));
    chk("bp_left",   64'(q.size()), 64'(0));

    // Reset with two ops in flight: neither may appear.
    for (int i = 0; i < 2; i++) begin
      drive_rand();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < NS + 2; i++) begin
      chk("flush_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    single("sbb", 32'd5, 32'd3, 2'b11, 1'b0, {4'b1000, 32'h0000_0001});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
